// File: rtl/priority_encoder_rr.sv
// Registered priority encoder with fixed-priority and round-robin selection behind a valid/ready handshake.
// Optional one-hot winner output is enabled with the PENC_ONEHOT_EN macro.
module priority_encoder_rr #(
  parameter  int WIDTH = 8,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] req_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic             mode_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [IDX_W-1:0] out_idx_o,
  output logic             out_any_o
`ifdef PENC_ONEHOT_EN
  ,output logic [WIDTH-1:0] out_onehot_o
`endif
);

  localparam logic [IDX_W-1:0] PTR_RESET = IDX_W'(WIDTH - 1);

  logic             valid_q, valid_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             any_q, any_d;
  logic             rr_q, rr_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;

  logic             capture;
  logic             deliver;
  logic [IDX_W-1:0] fix_idx;
  logic [IDX_W-1:0] rr_idx;
  logic [IDX_W-1:0] cand;
  logic             found;
  logic             req_any;

  assign in_ready_o = !valid_q || out_ready_i;
  assign capture    = in_valid_i && in_ready_o;
  assign deliver    = valid_q && out_ready_i;
  assign req_any    = |req_i;

  // Pointer moves past a delivered round-robin winner; the result feeds this cycle's search too.
  always_comb begin
    ptr_d = ptr_q;
    if (deliver && any_q && rr_q) begin
      ptr_d = (idx_q == '0) ? PTR_RESET : idx_q - IDX_W'(1);
    end
  end

  always_comb begin
    fix_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (req_i[i]) begin
        fix_idx = IDX_W'(i);
      end
    end
  end

  // Walk downward from the pointer with wrap; the first requester seen wins.
  always_comb begin
    rr_idx = '0;
    cand   = '0;
    found  = 1'b0;
    for (int k = 0; k < WIDTH; k++) begin
      if (int'(ptr_d) >= k) begin
        cand = IDX_W'(int'(ptr_d) - k);
      end else begin
        cand = IDX_W'(int'(ptr_d) + WIDTH - k);
      end
      if (!found && req_i[cand]) begin
        found  = 1'b1;
        rr_idx = cand;
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    idx_d   = idx_q;
    any_d   = any_q;
    rr_d    = rr_q;
    if (capture) begin
      valid_d = 1'b1;
      any_d   = req_any;
      rr_d    = mode_i;
      if (!req_any) begin
        idx_d = '0;
      end else if (mode_i) begin
        idx_d = rr_idx;
      end else begin
        idx_d = fix_idx;
      end
    end else if (deliver) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      idx_q   <= '0;
      any_q   <= 1'b0;
      rr_q    <= 1'b0;
      ptr_q   <= PTR_RESET;
    end else begin
      valid_q <= valid_d;
      idx_q   <= idx_d;
      any_q   <= any_d;
      rr_q    <= rr_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_valid_o = valid_q;
  assign out_idx_o   = idx_q;
  assign out_any_o   = any_q;

`ifdef PENC_ONEHOT_EN
  logic [WIDTH-1:0] onehot_q, onehot_d;

  always_comb begin
    onehot_d = onehot_q;
    if (capture) begin
      onehot_d = req_any ? (WIDTH'(1) << idx_d) : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      onehot_q <= '0;
    end else begin
      onehot_q <= onehot_d;
    end
  end

  assign out_onehot_o = onehot_q;
`endif

endmodule

// File: tb/tb_priority_encoder_rr.sv
// Directed bench for priority_encoder_rr: vector table plus hand-written reset, backpressure and one-hot sequences.
module tb_priority_encoder_rr;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic       inValid;
  logic       inReady;
  logic       mode;
  logic       outValid;
  logic       outReady;
  logic [2:0] outIdx;
  logic       outAny;

  int checkCount = 0;
  int passCount  = 0;

`ifdef PENC_ONEHOT_EN
  logic [7:0] outOnehot;
  logic [4:0] req5;
  logic       inValid5, inReady5, mode5, outValid5, outReady5, outAny5;
  logic [2:0] outIdx5;
  logic [4:0] outOnehot5;
`endif

  always #5 clk = ~clk;

  priority_encoder_rr #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (req),
    .in_valid_i  (inValid),
    .in_ready_o  (inReady),
    .mode_i      (mode),
    .out_valid_o (outValid),
    .out_ready_i (outReady),
    .out_idx_o   (outIdx),
    .out_any_o   (outAny)
`ifdef PENC_ONEHOT_EN
    ,.out_onehot_o(outOnehot)
`endif
  );

`ifdef PENC_ONEHOT_EN
  priority_encoder_rr #(.WIDTH(5)) dut5 (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_i        (req5),
    .in_valid_i   (inValid5),
    .in_ready_o   (inReady5),
    .mode_i       (mode5),
    .out_valid_o  (outValid5),
    .out_ready_i  (outReady5),
    .out_idx_o    (outIdx5),
    .out_any_o    (outAny5),
    .out_onehot_o (outOnehot5)
  );
`endif

  typedef struct {
    logic [7:0] req;
    logic       mode;
    logic [2:0] expIdx;
    logic       expAny;
  } vec_t;

  vec_t vecs[24];

  task automatic applyStimulus(input logic [7:0] r, input logic m, input logic v, input logic rdy);
    req      = r;
    mode     = m;
    inValid  = v;
    outReady = rdy;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end else begin
      passCount++;
    end
  endtask

  task automatic stepEdge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Back-to-back stream; round-robin expectations follow the pointer through each delivery.
    vecs[0]  = '{8'h2C, 1'b0, 3'd5, 1'b1};
    vecs[1]  = '{8'h00, 1'b0, 3'd0, 1'b0};
    vecs[2]  = '{8'hFF, 1'b1, 3'd7, 1'b1};
    vecs[3]  = '{8'hFF, 1'b1, 3'd6, 1'b1};
    vecs[4]  = '{8'hFF, 1'b1, 3'd5, 1'b1};
    vecs[5]  = '{8'hFF, 1'b1, 3'd4, 1'b1};
    vecs[6]  = '{8'hFF, 1'b1, 3'd3, 1'b1};
    vecs[7]  = '{8'hFF, 1'b1, 3'd2, 1'b1};
    vecs[8]  = '{8'hFF, 1'b1, 3'd1, 1'b1};
    vecs[9]  = '{8'hFF, 1'b1, 3'd0, 1'b1};
    vecs[10] = '{8'hFF, 1'b1, 3'd7, 1'b1};
    vecs[11] = '{8'hFF, 1'b1, 3'd6, 1'b1};
    vecs[12] = '{8'hFF, 1'b1, 3'd5, 1'b1};
    vecs[13] = '{8'hFF, 1'b1, 3'd4, 1'b1};
    vecs[14] = '{8'hFF, 1'b1, 3'd3, 1'b1};
    vecs[15] = '{8'hFF, 1'b1, 3'd2, 1'b1};
    vecs[16] = '{8'hFF, 1'b1, 3'd1, 1'b1};
    vecs[17] = '{8'h84, 1'b1, 3'd7, 1'b1};
    vecs[18] = '{8'h84, 1'b1, 3'd2, 1'b1};
    vecs[19] = '{8'h84, 1'b0, 3'd7, 1'b1};
    vecs[20] = '{8'h84, 1'b1, 3'd7, 1'b1};
    vecs[21] = '{8'h00, 1'b1, 3'd0, 1'b0};
    vecs[22] = '{8'h01, 1'b1, 3'd0, 1'b1};
    vecs[23] = '{8'h80, 1'b1, 3'd7, 1'b1};

    rst_n = 1'b0;
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b1);
`ifdef PENC_ONEHOT_EN
    req5 = '0; mode5 = 1'b0; inValid5 = 1'b0; outReady5 = 1'b1;
`endif
    #1;
    checkOutput("reset_out_valid", 32'(outValid), 32'd0);
    checkOutput("reset_out_idx",   32'(outIdx),   32'd0);
    checkOutput("reset_out_any",   32'(outAny),   32'd0);
    checkOutput("reset_in_ready",  32'(inReady),  32'd1);
`ifdef PENC_ONEHOT_EN
    checkOutput("reset_out_onehot", 32'(outOnehot), 32'd0);
`endif
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 24; i++) begin
      logic [7:0] expOh;
      applyStimulus(vecs[i].req, vecs[i].mode, 1'b1, 1'b1);
      stepEdge();
      checkOutput($sformatf("vec%0d_valid", i), 32'(outValid), 32'd1);
      checkOutput($sformatf("vec%0d_idx", i),   32'(outIdx),   32'(vecs[i].expIdx));
      checkOutput($sformatf("vec%0d_any", i),   32'(outAny),   32'(vecs[i].expAny));
      expOh = vecs[i].expAny ? (8'h01 << vecs[i].expIdx) : 8'h00;
`ifdef PENC_ONEHOT_EN
      checkOutput($sformatf("vec%0d_onehot", i), 32'(outOnehot), 32'(expOh));
`endif
    end

    applyStimulus(8'h00, 1'b0, 1'b0, 1'b1);
    stepEdge();
    checkOutput("drain_valid", 32'(outValid), 32'd0);

    // Stall with pending round-robin result; new requests must be ignored.
    applyStimulus(8'h10, 1'b1, 1'b1, 1'b1);
    stepEdge();
    checkOutput("bp_capture_idx", 32'(outIdx), 32'd4);
    applyStimulus(8'hFF, 1'b1, 1'b1, 1'b0);
    for (int c = 0; c < 3; c++) begin
      #1;
      checkOutput($sformatf("bp%0d_in_ready", c), 32'(inReady), 32'd0);
      stepEdge();
      checkOutput($sformatf("bp%0d_valid", c), 32'(outValid), 32'd1);
      checkOutput($sformatf("bp%0d_idx", c),   32'(outIdx),   32'd4);
      checkOutput($sformatf("bp%0d_any", c),   32'(outAny),   32'd1);
    end
    applyStimulus(8'hFF, 1'b1, 1'b1, 1'b1);
    #1;
    checkOutput("bp_release_in_ready", 32'(inReady), 32'd1);
    stepEdge();
    checkOutput("bp_release_idx", 32'(outIdx), 32'd3);

    // Reset with a pending result whose pointer would otherwise give 2.
    applyStimulus(8'hFF, 1'b1, 1'b0, 1'b0);
    #1;
    checkOutput("pre_reset_valid", 32'(outValid), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_reset_valid",    32'(outValid), 32'd0);
    checkOutput("mid_reset_idx",      32'(outIdx),   32'd0);
    checkOutput("mid_reset_any",      32'(outAny),   32'd0);
    checkOutput("mid_reset_in_ready", 32'(inReady),  32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(8'hFF, 1'b1, 1'b1, 1'b1);
    stepEdge();
    checkOutput("post_reset_valid", 32'(outValid), 32'd1);
    checkOutput("post_reset_idx",   32'(outIdx),   32'd7);

`ifdef PENC_ONEHOT_EN
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b1);
    req5 = 5'b01010; mode5 = 1'b0; inValid5 = 1'b1; outReady5 = 1'b1;
    stepEdge();
    checkOutput("w5_idx",    32'(outIdx5),    32'd3);
    checkOutput("w5_onehot", 32'(outOnehot5), 32'h08);
    req5 = 5'b00000;
    stepEdge();
    checkOutput("w5_zero_valid",  32'(outValid5),  32'd1);
    checkOutput("w5_zero_any",    32'(outAny5),    32'd0);
    checkOutput("w5_zero_onehot", 32'(outOnehot5), 32'd0);
    inValid5 = 1'b0;
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
